game_frame_renderer: RTL

Consumes the per-pixel game stream produced by the game logic controller: pixel coordinates, wall/person/collision flags, depths and game state. Produces a 24-bit RGB pixel stream for the HDMI path. Accumulates per-frame collision-pixel counts and runs a three-state display state machine (normal play, hit flash, game over). Sits between the game logic controller and the video output encoder, two cycles of pipeline latency.

---
 rtl/game_render_pkg.sv | 46 ++++
 rtl/collision_frame_counter.sv | 73 +++++++
 rtl/game_frame_renderer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_render_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_render_pkg
//  Description : Shared types and constants for the game frame renderer:
//                display state enum, stage-1 colour class, packed RGB pixel,
//                fixed palette entries and the wall-shade helper.
//  Revision    : 1.0  initial release
// ============================================================================
package game_render_pkg;

    typedef enum logic [1:0] {
        PLAYING   = 2'd0,
        HIT_FLASH = 2'd1,
        GAME_OVER = 2'd2
    } render_state_t;

    // Colour class resolved in stage 1; stage 2 turns it into RGB.
    typedef enum logic [2:0] {
        CLS_BG       = 3'd0,
        CLS_WALL     = 3'd1,
        CLS_PERSON   = 3'd2,
        CLS_NEAR_HIT = 3'd3,
        CLS_HIT      = 3'd4,
        CLS_BORDER   = 3'd5
    } colour_class_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam pixel_t COLOR_BORDER   = 24'hFFFF00;
    localparam pixel_t COLOR_HIT      = 24'hFF0000;
    localparam pixel_t COLOR_NEAR_HIT = 24'hFF8000;
    localparam pixel_t COLOR_BG       = 24'h202020;

    // Blue intensity of a wall pixel: 3*depth, saturated to 8 bits.
    function automatic logic [7:0] wall_blue(input logic [7:0] depth);
        logic [9:0] triple;
        triple = {2'b00, depth} + {1'b0, depth, 1'b0};
        return (triple > 10'd255) ? 8'hFF : triple[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/collision_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module      : collision_frame_counter
//  Description : Counts in-window collision pixels over a frame, latches the
//                total at the last active pixel and pulses on a frame hit.
//  Ports       : clk_i, rst_n_i         clock, async active-low reset
//                hcount_i, vcount_i     pixel coordinates
//                data_valid_i           pixel qualifier
//                collision_i, in_window_i  pixel is an in-window collision
//                frame_end_o            comb: this pixel closes the frame
//                frame_hit_now_o        comb: closing frame meets threshold
//                count_o                latched count of last frame
//                hit_pulse_o            one-cycle hit pulse
//  Revision    : 1.0  initial release
// ============================================================================
module collision_frame_counter
    import game_render_pkg::*;
#(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int COLLISION_THRESHOLD = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic        data_valid_i,
    input  logic        collision_i,
    input  logic        in_window_i,
    output logic        frame_end_o,
    output logic        frame_hit_now_o,
    output logic [20:0] count_o,
    output logic        hit_pulse_o
);

    localparam logic [10:0] C_LAST_H = 11'(SCREEN_WIDTH - 1);
    localparam logic [9:0]  C_LAST_V = 10'(SCREEN_HEIGHT - 1);
    localparam logic [20:0] C_THRESH = 21'(COLLISION_THRESHOLD);

    logic [20:0] acc_q;
    logic [20:0] acc_d;
    logic [20:0] total;
    logic [20:0] count_q;
    logic        hit_q;
    logic        inc;

    assign inc         = data_valid_i && collision_i && in_window_i;
    assign frame_end_o = data_valid_i && (hcount_i == C_LAST_H) && (vcount_i == C_LAST_V);

    // Running total including the current pixel, held at all-ones.
    assign total           = (inc && (acc_q != '1)) ? acc_q + 21'd1 : acc_q;
    assign frame_hit_now_o = (total >= C_THRESH);
    assign acc_d           = frame_end_o ? '0 : total;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q   <= '0;
            count_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            hit_q <= frame_end_o && frame_hit_now_o;
            if (frame_end_o) begin
                count_q <= total;
            end
        end
    end

    assign count_o     = count_q;
    assign hit_pulse_o = hit_q;

endmodule
`default_nettype wire

// File: rtl/game_frame_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : game_frame_renderer
//  Description : Two-stage pixel shader between the game logic controller and
//                the video encoder, with per-frame collision counting and a
//                PLAYING / HIT_FLASH / GAME_OVER display state machine.
//  Ports       : clk_in, rst_n_in           pixel clock, async active-low reset
//                hcount_in, vcount_in        pixel coordinates
//                data_valid_in               pixel qualifier
//                wall_depth_in, player_depth_in  depths at pixel
//                is_wall_in, is_person_in, is_collision_in  pixel flags
//                game_state_in               0 = lost, otherwise running
//                hcount_out, vcount_out, data_valid_out  delayed 2 cycles
//                pixel_out                   {R,G,B}
//                collision_count_out         last frame's in-window count
//                frame_hit_out               one-cycle frame hit pulse
//                render_state_out            display state
//  Revision    : 1.0  initial release
// ============================================================================
module game_frame_renderer
    import game_render_pkg::*;
#(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int COLLISION_THRESHOLD = 64,
    parameter int FLASH_FRAMES        = 30,
    parameter int BORDER_PX           = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic [7:0]  wall_depth_in,
    input  logic [7:0]  player_depth_in,
    input  logic        is_wall_in,
    input  logic        is_person_in,
    input  logic        is_collision_in,
    input  logic [2:0]  game_state_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        data_valid_out,
    output logic [23:0] pixel_out,
    output logic [20:0] collision_count_out,
    output logic        frame_hit_out,
    output logic [1:0]  render_state_out
);

    localparam int C_WIN_LO  = GOAL_DEPTH - GOAL_DEPTH_DELTA;
    localparam int C_WIN_HI  = GOAL_DEPTH + GOAL_DEPTH_DELTA;
    localparam int C_FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam logic [C_FLASH_W-1:0] C_FLASH_LAST = C_FLASH_W'(FLASH_FRAMES);

    // ------------------------------------------------------------------
    // Pixel classification
    // ------------------------------------------------------------------
    logic          in_window;
    logic          border;
    colour_class_t cls;

    assign in_window = (int'(wall_depth_in) >= C_WIN_LO) && (int'(wall_depth_in) <= C_WIN_HI);
    assign border    = (int'(hcount_in) < BORDER_PX) ||
                       (int'(hcount_in) >= SCREEN_WIDTH - BORDER_PX) ||
                       (int'(vcount_in) < BORDER_PX) ||
                       (int'(vcount_in) >= SCREEN_HEIGHT - BORDER_PX);

    always_comb begin
        cls = CLS_BG;
        if (border && in_window)                cls = CLS_BORDER;
        else if (is_collision_in && in_window)  cls = CLS_HIT;
        else if (is_collision_in)               cls = CLS_NEAR_HIT;
        else if (is_person_in)                  cls = CLS_PERSON;
        else if (is_wall_in)                    cls = CLS_WALL;
    end

    // ------------------------------------------------------------------
    // Collision accounting
    // ------------------------------------------------------------------
    logic frame_end;
    logic frame_hit_now;

    collision_frame_counter #(
        .SCREEN_WIDTH        (SCREEN_WIDTH),
        .SCREEN_HEIGHT       (SCREEN_HEIGHT),
        .COLLISION_THRESHOLD (COLLISION_THRESHOLD)
    ) u_counter (
        .clk_i           (clk_in),
        .rst_n_i         (rst_n_in),
        .hcount_i        (hcount_in),
        .vcount_i        (vcount_in),
        .data_valid_i    (data_valid_in),
        .collision_i     (is_collision_in),
        .in_window_i     (in_window),
        .frame_end_o     (frame_end),
        .frame_hit_now_o (frame_hit_now),
        .count_o         (collision_count_out),
        .hit_pulse_o     (frame_hit_out)
    );

    // ------------------------------------------------------------------
    // Display state machine, advanced only on the last pixel of a frame
    // ------------------------------------------------------------------
    render_state_t          state_q, state_d;
    logic [C_FLASH_W-1:0]   flash_q, flash_d;
    logic [C_FLASH_W-1:0]   flash_inc;
    logic                   lost;

    assign lost      = (game_state_in == 3'd0);
    assign flash_inc = flash_q + C_FLASH_W'(1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= PLAYING;
            flash_q <= '0;
        end else begin
            state_q <= state_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flash_d = flash_q;
        if (frame_end) begin
            case (state_q)
                PLAYING: begin
                    flash_d = '0;
                    if (lost)               state_d = GAME_OVER;
                    else if (frame_hit_now) state_d = HIT_FLASH;
                end
                HIT_FLASH: begin
                    if (flash_inc == C_FLASH_LAST) begin
                        flash_d = '0;
                        state_d = lost ? GAME_OVER : PLAYING;
                    end else if (lost) begin
                        flash_d = '0;
                        state_d = GAME_OVER;
                    end else begin
                        flash_d = flash_inc;
                    end
                end
                GAME_OVER: begin
                    flash_d = '0;
                    if (!lost) state_d = PLAYING;
                end
                default: begin
                    flash_d = '0;
                    state_d = PLAYING;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register pixel, class and the display mode it was seen in.
    // Capturing the mode here keeps the frame's last pixel on the old state.
    // ------------------------------------------------------------------
    logic [10:0]   h1_q;
    logic [9:0]    v1_q;
    logic          valid1_q;
    logic [7:0]    wall1_q;
    logic [7:0]    player1_q;
    colour_class_t cls1_q;
    render_state_t mode1_q;
    logic          invert1_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            h1_q      <= '0;
            v1_q      <= '0;
            valid1_q  <= 1'b0;
            wall1_q   <= '0;
            player1_q <= '0;
            cls1_q    <= CLS_BG;
            mode1_q   <= PLAYING;
            invert1_q <= 1'b0;
        end else begin
            h1_q      <= hcount_in;
            v1_q      <= vcount_in;
            valid1_q  <= data_valid_in;
            wall1_q   <= wall_depth_in;
            player1_q <= player_depth_in;
            cls1_q    <= cls;
            mode1_q   <= state_q;
            invert1_q <= flash_q[0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: RGB and state modifier
    // ------------------------------------------------------------------
    pixel_t base;
    pixel_t shaded;

    always_comb begin
        base = COLOR_BG;
        case (cls1_q)
            CLS_BORDER:   base = COLOR_BORDER;
            CLS_HIT:      base = COLOR_HIT;
            CLS_NEAR_HIT: base = COLOR_NEAR_HIT;
            CLS_PERSON:   base = '{r: 8'h00, g: 8'hFF - player1_q, b: 8'h00};
            CLS_WALL:     base = '{r: 8'h00, g: 8'h00, b: wall_blue(wall1_q)};
            default:      base = COLOR_BG;
        endcase
    end

    always_comb begin
        shaded = base;
        case (mode1_q)
            HIT_FLASH: if (invert1_q) shaded = base ^ 24'hFFFFFF;
            GAME_OVER: shaded = '{r: 8'hFF, g: {2'b00, base.g[7:2]}, b: {2'b00, base.b[7:2]}};
            default:   shaded = base;
        endcase
    end

    logic [10:0] h2_q;
    logic [9:0]  v2_q;
    logic        valid2_q;
    pixel_t      pixel2_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            h2_q     <= '0;
            v2_q     <= '0;
            valid2_q <= 1'b0;
            pixel2_q <= '0;
        end else begin
            h2_q     <= h1_q;
            v2_q     <= v1_q;
            valid2_q <= valid1_q;
            pixel2_q <= shaded;
        end
    end

    assign hcount_out       = h2_q;
    assign vcount_out       = v2_q;
    assign data_valid_out   = valid2_q;
    assign pixel_out        = pixel2_q;
    assign render_state_out = state_q;

endmodule
`default_nettype wire
